// File: rtl/i2s_tx_scheduler.sv
`default_nettype none
// ============================================================================
// i2s_tx_scheduler : primes a stereo-frame FIFO and reloads I2S holding regs
// Rev 1.0
// ============================================================================
module i2s_tx_scheduler #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int PRIME = 2
) (
  input  logic                     sclk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     ws_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [WIDTH-1:0]         push_left_i,
  input  logic [WIDTH-1:0]         push_right_i,
  output logic [WIDTH-1:0]         left_tx_o,
  output logic [WIDTH-1:0]         right_tx_o,
  output logic                     frame_o,
  output logic                     underrun_o,
  input  logic                     underrun_clr_i,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] LVL_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_PRIME = LW'(PRIME);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             ws_q;
  logic [LW-1:0]    level_q, level_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic             frame_q, frame_d;
  logic             underrun_q, underrun_d;

  logic [WIDTH-1:0] mem_left_q  [DEPTH];
  logic [WIDTH-1:0] mem_right_q [DEPTH];

  logic boundary;
  logic push;
  logic pop;
  logic uflow;
  logic flush;

  always_comb begin
    boundary     = ws_q & ~ws_i;
    push_ready_o = (state_q != ST_IDLE) && (level_q < LVL_DEPTH);
    push         = push_valid_i & push_ready_o;
    flush        = ~en_i;
    pop          = 1'b0;
    uflow        = 1'b0;
    state_d      = state_q;
    left_d       = left_q;
    right_d      = right_q;
    frame_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_i) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (level_q >= LVL_PRIME) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (boundary) begin
          frame_d = 1'b1;
          if (level_q != '0) begin
            pop     = 1'b1;
            left_d  = mem_left_q[rd_ptr_q];
            right_d = mem_right_q[rd_ptr_q];
          end else begin
            // Starved: transmit silence and re-prime before resuming.
            uflow   = 1'b1;
            left_d  = '0;
            right_d = '0;
            state_d = ST_PRIME;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable abandons any frame in flight and empties the FIFO.
    if (flush) begin
      state_d = ST_IDLE;
      left_d  = '0;
      right_d = '0;
      frame_d = 1'b0;
      pop     = 1'b0;
      uflow   = 1'b0;
    end

    if (flush) begin
      level_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end

    if (uflow) begin
      underrun_d = 1'b1;
    end else if (underrun_clr_i) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ws_q       <= 1'b1;
      level_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      left_q     <= '0;
      right_q    <= '0;
      frame_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ws_q       <= ws_i;
      level_q    <= level_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      left_q     <= left_d;
      right_q    <= right_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge sclk) begin
    if (push && !flush) begin
      mem_left_q[wr_ptr_q]  <= push_left_i;
      mem_right_q[wr_ptr_q] <= push_right_i;
    end
  end

  assign left_tx_o  = left_q;
  assign right_tx_o = right_q;
  assign frame_o    = frame_q;
  assign underrun_o = underrun_q;
  assign level_o    = level_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_scheduler.sv
`default_nettype none
// ============================================================================
// tb_i2s_tx_scheduler : scoreboard bench for i2s_tx_scheduler (DEPTH=4, PRIME=2)
// Rev 1.0
// ============================================================================
module tb_i2s_tx_scheduler;

  localparam int WIDTH = 16;

  logic             sclk;
  logic             rst;
  logic             en_i;
  logic             ws_i;
  logic             push_valid_i;
  logic             push_ready_o;
  logic [WIDTH-1:0] push_left_i;
  logic [WIDTH-1:0] push_right_i;
  logic [WIDTH-1:0] left_tx_o;
  logic [WIDTH-1:0] right_tx_o;
  logic             frame_o;
  logic             underrun_o;
  logic             underrun_clr_i;
  logic [2:0]       level_o;

  int errors = 0;
  int checks = 0;

  // Expected {left,right} per frame_o pulse, in transmit order.
  logic [2*WIDTH-1:0] exp_q[$];

  i2s_tx_scheduler #(.WIDTH(WIDTH), .DEPTH(4), .PRIME(2)) dut (
    .sclk           (sclk),
    .rst            (rst),
    .en_i           (en_i),
    .ws_i           (ws_i),
    .push_valid_i   (push_valid_i),
    .push_ready_o   (push_ready_o),
    .push_left_i    (push_left_i),
    .push_right_i   (push_right_i),
    .left_tx_o      (left_tx_o),
    .right_tx_o     (right_tx_o),
    .frame_o        (frame_o),
    .underrun_o     (underrun_o),
    .underrun_clr_i (underrun_clr_i),
    .level_o        (level_o)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Scoreboard: record accepted pushes, compare each frame pulse.
  always @(negedge sclk) begin
    if (!rst && en_i && push_valid_i && push_ready_o)
      exp_q.push_back({push_left_i, push_right_i});
    if (!rst && frame_o) begin
      if (exp_q.size() == 0) begin
        check("frame_unexpected", 1, 0);
      end else begin
        logic [2*WIDTH-1:0] e;
        e = exp_q.pop_front();
        check("frame_data", {left_tx_o, right_tx_o}, e);
      end
    end
  end

  task automatic push(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    push_valid_i = 1'b1;
    push_left_i  = l;
    push_right_i = r;
    tick();
    push_valid_i = 1'b0;
  endtask

  // ws high for one edge, then low: the second edge is a frame boundary.
  task automatic boundary(input bit do_push, input logic [WIDTH-1:0] l,
                          input logic [WIDTH-1:0] r, input bit do_clr);
    ws_i = 1'b1;
    tick();
    ws_i = 1'b0;
    if (do_push) begin
      push_valid_i = 1'b1;
      push_left_i  = l;
      push_right_i = r;
    end
    underrun_clr_i = do_clr;
    tick();
    if (do_push) push_valid_i = 1'b0;
    underrun_clr_i = 1'b0;
  endtask

  task automatic clr_pulse();
    underrun_clr_i = 1'b1;
    tick();
    underrun_clr_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b0; ws_i = 1'b1; push_valid_i = 1'b0;
    push_left_i = '0; push_right_i = '0; underrun_clr_i = 1'b0;
    repeat (3) tick();

    check("rst_level", level_o, 0);
    check("rst_ready", push_ready_o, 0);
    check("rst_left", left_tx_o, 0);
    check("rst_right", right_tx_o, 0);
    check("rst_frame", frame_o, 0);
    check("rst_underrun", underrun_o, 0);

    // Basic run
    rst = 1'b0; en_i = 1'b1;
    tick();
    check("prime_ready", push_ready_o, 1);
    push(16'hdead, 16'hbeef);
    push(16'h1234, 16'h5678);
    check("prime_level", level_o, 2);
    tick();
    boundary(0, '0, '0, 0);
    check("basic_b1", {left_tx_o, right_tx_o}, 32'hdeadbeef);
    check("basic_b1_frame", frame_o, 1);
    boundary(0, '0, '0, 0);
    check("basic_b2", {left_tx_o, right_tx_o}, 32'h12345678);
    check("basic_level0", level_o, 0);

    // Full FIFO, then refused push on a boundary
    for (int i = 0; i < 4; i++) push(16'($urandom), 16'($urandom));
    check("full_ready", push_ready_o, 0);
    check("full_level", level_o, 4);
    push_valid_i = 1'b1; push_left_i = 16'heeee; push_right_i = 16'heeee;
    tick();
    check("full_5th_refused", level_o, 4);
    boundary(0, '0, '0, 0);
    push_valid_i = 1'b0;
    check("full_pop_level", level_o, 3);
    check("full_ready_back", push_ready_o, 1);

    // Simultaneous push/pop at level 2
    boundary(0, '0, '0, 0);
    check("sim_level2", level_o, 2);
    boundary(1, 16'h0a0a, 16'h0b0b, 0);
    check("sim_level_same", level_o, 2);
    boundary(0, '0, '0, 0);
    boundary(0, '0, '0, 0);
    check("sim_order_last", {left_tx_o, right_tx_o}, 32'h0a0a0b0b);
    check("drain_level", level_o, 0);

    // Underrun with simultaneous push
    exp_q.push_back('0);
    boundary(1, 16'haaaa, 16'h5555, 0);
    check("ur_flag", underrun_o, 1);
    check("ur_hold", {left_tx_o, right_tx_o}, 32'h0);
    check("ur_level", level_o, 1);
    boundary(0, '0, '0, 0);
    check("ur_prime_no_pop", level_o, 1);
    check("ur_sticky", underrun_o, 1);
    clr_pulse();
    check("ur_cleared", underrun_o, 0);
    push(16'hbbbb, 16'hcccc);
    tick();
    boundary(0, '0, '0, 0);
    check("ur_resume", {left_tx_o, right_tx_o}, 32'haaaa5555);
    boundary(0, '0, '0, 0);
    exp_q.push_back('0);
    boundary(0, '0, '0, 1);
    check("ur_set_wins", underrun_o, 1);
    clr_pulse();
    check("ur_cleared2", underrun_o, 0);

    // Disable mid-RUN with level 3, boundary abandoned
    for (int i = 0; i < 4; i++) push(16'h1000 + 16'(i), 16'h2000 + 16'(i));
    boundary(0, '0, '0, 0);
    check("dis_pre_level", level_o, 3);
    check("dis_pre_left", left_tx_o, 16'h1000);
    ws_i = 1'b1;
    tick();
    ws_i = 1'b0; en_i = 1'b0;
    tick();
    exp_q.delete();
    check("dis_level", level_o, 0);
    check("dis_hold", {left_tx_o, right_tx_o}, 32'h0);
    check("dis_frame", frame_o, 0);
    check("dis_ready", push_ready_o, 0);

    // Reset mid-operation
    en_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) push(16'h3000 + 16'(i), 16'h4000 + 16'(i));
    boundary(0, '0, '0, 0);
    check("rmid_level", level_o, 2);
    rst = 1'b1; push_valid_i = 1'b1; push_left_i = 16'h7777; ws_i = 1'b1;
    tick();
    exp_q.delete();
    push_valid_i = 1'b0;
    check("rmid_level0", level_o, 0);
    check("rmid_ready", push_ready_o, 0);
    check("rmid_hold", {left_tx_o, right_tx_o}, 32'h0);
    check("rmid_frame", frame_o, 0);
    check("rmid_underrun", underrun_o, 0);

    rst = 1'b0;
    tick();
    push(16'h9abc, 16'hdef0);
    push(16'h1111, 16'h2222);
    tick();
    boundary(0, '0, '0, 0);
    check("post_rst_b1", {left_tx_o, right_tx_o}, 32'h9abcdef0);
    boundary(0, '0, '0, 0);
    tick();
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_tx_scheduler.md
I2S_TX_SCHEDULER -- requirements
Module: i2s_tx_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width per channel.
REQ-002 SHALL have parameter DEPTH, default 4, stereo-frame FIFO depth; power of two, at least 2.
REQ-003 SHALL have parameter PRIME, default 2, FIFO level required before the block starts transmitting; range 1..DEPTH.
REQ-004 SHALL have port sclk  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port en_i  in  1  scheduler enable.
REQ-007 SHALL have port ws_i  in  1  word select from the I2S transmitter (low = left half-frame).
REQ-008 SHALL have port push_valid_i  in  1  producer offers a stereo frame.
REQ-009 SHALL have port push_ready_o  out  1  scheduler accepts a frame.
REQ-010 SHALL have port push_left_i  in  WIDTH  left sample.
REQ-011 SHALL have port push_right_i  in  WIDTH  right sample.
REQ-012 SHALL have port left_tx_o  out  WIDTH  left holding register driving the transmitter.
REQ-013 SHALL have port right_tx_o  out  WIDTH  right holding register driving the transmitter.
REQ-014 SHALL have port frame_o  out  1  one-cycle pulse, high in the cycle after the holding registers update.
REQ-015 SHALL have port underrun_o  out  1  sticky underrun flag.
REQ-016 SHALL have port underrun_clr_i  in  1  clears underrun_o.
REQ-017 SHALL have port level_o  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-018 SHALL register ws_i into ws_q. A frame boundary is the condition ws_q=1 and ws_i=0.
REQ-019 SHALL accept a push when push_valid_i=1 and push_ready_o=1; push_ready_o = (state!=IDLE) and (level<DEPTH), computed from current-cycle state only.
REQ-020 SHALL implement the states IDLE, PRIME and RUN.
REQ-021 IDLE: SHALL hold the FIFO empty and hold the outputs at zero; SHALL go to PRIME when en_i=1.
REQ-022 PRIME: SHALL accept pushes and pop nothing; SHALL go to RUN when level>=PRIME, with the transition taking effect at the next clock edge.
REQ-023 RUN with a boundary and level>0: SHALL pop the FIFO head into left_tx_o/right_tx_o at that edge; frame_o SHALL be 1 in the following cycle; state SHALL remain RUN.
REQ-024 RUN with a boundary and level=0: SHALL load zeros into both holding registers, set underrun_o, pulse frame_o, and go to PRIME.
REQ-025 Between boundaries, the holding registers SHALL hold their value.
REQ-026 Push and pop in the same cycle: SHALL leave level unchanged; the pushed frame goes to the tail.
REQ-027 Push in the same cycle as an empty-FIFO boundary: SHALL treat it as an underrun; the pushed frame is stored and transmitted at the next frame after re-priming.
REQ-028 en_i=0 in any state: SHALL go to IDLE at the next edge, flush the FIFO (level=0), and zero the holding registers.
REQ-029 An in-progress frame at en_i=0 SHALL be abandoned, with no frame_o pulse.
REQ-030 SHALL keep underrun_o set until underrun_clr_i=1.
REQ-031 If a set event and underrun_clr_i occur in the same cycle, set SHALL win.
REQ-032 FIFO pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-033 level SHALL never exceed DEPTH or go below 0.
REQ-034 Latency: a frame pushed into an empty RUN-state FIFO SHALL appear on the holding registers at the first boundary strictly after the push cycle.

Reset
REQ-035 While rst=1: state=IDLE, ws_q=1, level_o=0, read/write pointers=0, left_tx_o=0, right_tx_o=0, frame_o=0, underrun_o=0, push_ready_o=0.
REQ-036 Reset SHALL take priority over all other inputs, including mid-frame and mid-push.
REQ-037 FIFO storage need not be reset.

Verification
REQ-038 Basic run: rst released, en_i=1, push (dead,beef) then (1234,5678) -> RUN; at the 1st boundary left_tx_o=dead, right_tx_o=beef; at the 2nd boundary 1234/5678; frame_o pulses once per boundary.
REQ-039 Full: push 5 frames with no boundary (DEPTH=4) -> push_ready_o=0 after the 4th push, level_o=4, 5th frame not accepted; one boundary -> level_o=3, ready returns to 1.
REQ-040 Underrun: in RUN with level_o=0 at a boundary -> holding registers=0000/0000, underrun_o=1, state=PRIME; underrun_clr_i pulse -> underrun_o=0.
REQ-041 Simultaneous: push while level_o=4 at a boundary -> push refused, level_o=3; push at level_o=2 on a boundary -> level_o stays 2, FIFO order preserved.
REQ-042 Disable: en_i=0 mid-RUN with level_o=3 -> next cycle state=IDLE, level_o=0, outputs 0000/0000, no frame_o.
REQ-043 Reset mid-operation: rst=1 during RUN with level_o=2 -> all outputs equal their REQ-035 values on the next cycle.
